// File: rtl/clk_monitor_if.sv
// Bundle between the clock monitor and whoever drives/observes it: enable and
// monitored clock in, measurement results and status out.
interface clk_monitor_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             enable;
    logic             mon_clk;
    logic             meas_valid;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             err_period;
    logic             err_duty;
    logic             stuck;
    logic             locked;

    modport master (
        output enable, mon_clk,
        input  meas_valid, period, high_time, err_period, err_duty, stuck, locked
    );

    modport slave (
        input  enable, mon_clk,
        output meas_valid, period, high_time, err_period, err_duty, stuck, locked
    );
endinterface

// File: rtl/clk_monitor.sv
// Measures period and high time of an asynchronous clock in clk cycles, flags
// out-of-range measurements, detects a stuck clock and reports lock.
module clk_monitor #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EXP_PERIOD  = 10,
    parameter int unsigned PERIOD_TOL  = 1,
    parameter int unsigned MIN_HIGH    = 4,
    parameter int unsigned MAX_HIGH    = 6,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned LOCK_COUNT  = 4
) (
    input  logic          clk,
    input  logic          rst,
    clk_monitor_if.slave  bus
);
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_MEAS = 2'd2;

    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [TO_W-1:0]   TO_LIMIT   = TO_W'(TIMEOUT);
    localparam logic [GOOD_W-1:0] GOOD_LIMIT = GOOD_W'(LOCK_COUNT);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   w_s;
    logic                   w_rise;

    logic [1:0]        r_state,      w_state_nxt;
    logic [CNT_W-1:0]  r_per_cnt,    w_per_cnt_nxt;
    logic [CNT_W-1:0]  r_hi_cnt,     w_hi_cnt_nxt;
    logic [TO_W-1:0]   r_to_cnt,     w_to_cnt_nxt;
    logic [GOOD_W-1:0] r_good_cnt,   w_good_cnt_nxt;
    logic              r_meas_valid, w_meas_valid_nxt;
    logic [CNT_W-1:0]  r_period,     w_period_nxt;
    logic [CNT_W-1:0]  r_high_time,  w_high_time_nxt;
    logic              r_err_period, w_err_period_nxt;
    logic              r_err_duty,   w_err_duty_nxt;
    logic              r_stuck,      w_stuck_nxt;
    logic              r_locked,     w_locked_nxt;

    logic              w_to_hit;
    logic              w_err_p;
    logic              w_err_d;
    logic [GOOD_W-1:0] w_good_inc;
    logic [31:0]       w_per_ext;
    logic [31:0]       w_hi_ext;

    // Metastability synchronizer plus edge-detect flop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.mon_clk};
            r_s_d  <= w_s;
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_s_d;

    // 32-bit compares keep (period + tol < exp) free of underflow and overflow
    assign w_per_ext  = 32'(r_per_cnt);
    assign w_hi_ext   = 32'(r_hi_cnt);
    assign w_err_p    = (w_per_ext > EXP_PERIOD + PERIOD_TOL) || (w_per_ext + PERIOD_TOL < EXP_PERIOD);
    assign w_err_d    = (w_hi_ext < MIN_HIGH) || (w_hi_ext > MAX_HIGH);
    assign w_to_hit   = (r_to_cnt + TO_W'(1)) == TO_LIMIT;
    assign w_good_inc = (r_good_cnt == GOOD_LIMIT) ? r_good_cnt : r_good_cnt + GOOD_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_per_cnt    <= '0;
            r_hi_cnt     <= '0;
            r_to_cnt     <= '0;
            r_good_cnt   <= '0;
            r_meas_valid <= 1'b0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_err_period <= 1'b0;
            r_err_duty   <= 1'b0;
            r_stuck      <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_per_cnt    <= w_per_cnt_nxt;
            r_hi_cnt     <= w_hi_cnt_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
            r_good_cnt   <= w_good_cnt_nxt;
            r_meas_valid <= w_meas_valid_nxt;
            r_period     <= w_period_nxt;
            r_high_time  <= w_high_time_nxt;
            r_err_period <= w_err_period_nxt;
            r_err_duty   <= w_err_duty_nxt;
            r_stuck      <= w_stuck_nxt;
            r_locked     <= w_locked_nxt;
        end
    end

    // Rise beats timeout; disable beats everything
    always_comb begin
        w_state_nxt      = r_state;
        w_per_cnt_nxt    = r_per_cnt;
        w_hi_cnt_nxt     = r_hi_cnt;
        w_to_cnt_nxt     = r_to_cnt;
        w_good_cnt_nxt   = r_good_cnt;
        w_meas_valid_nxt = 1'b0;
        w_period_nxt     = r_period;
        w_high_time_nxt  = r_high_time;
        w_err_period_nxt = r_err_period;
        w_err_duty_nxt   = r_err_duty;
        w_stuck_nxt      = r_stuck;
        w_locked_nxt     = r_locked;

        if (!bus.enable) begin
            w_state_nxt    = S_IDLE;
            w_per_cnt_nxt  = '0;
            w_hi_cnt_nxt   = '0;
            w_to_cnt_nxt   = '0;
            w_good_cnt_nxt = '0;
            w_stuck_nxt    = 1'b0;
            w_locked_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_ARM;
                S_ARM: begin
                    if (w_rise) begin
                        w_state_nxt   = S_MEAS;
                        w_per_cnt_nxt = CNT_W'(1);
                        w_hi_cnt_nxt  = CNT_W'(1);
                        w_to_cnt_nxt  = '0;
                        w_stuck_nxt   = 1'b0;
                    end else if (w_to_hit) begin
                        w_to_cnt_nxt   = '0;
                        w_stuck_nxt    = 1'b1;
                        w_good_cnt_nxt = '0;
                        w_locked_nxt   = 1'b0;
                    end else begin
                        w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                    end
                end
                S_MEAS: begin
                    if (w_rise) begin
                        w_meas_valid_nxt = 1'b1;
                        w_period_nxt     = r_per_cnt;
                        w_high_time_nxt  = r_hi_cnt;
                        w_err_period_nxt = w_err_p;
                        w_err_duty_nxt   = w_err_d;
                        w_per_cnt_nxt    = CNT_W'(1);
                        w_hi_cnt_nxt     = CNT_W'(1);
                        w_to_cnt_nxt     = '0;
                        w_stuck_nxt      = 1'b0;
                        if (!w_err_p && !w_err_d) begin
                            w_good_cnt_nxt = w_good_inc;
                            w_locked_nxt   = (w_good_inc == GOOD_LIMIT);
                        end else begin
                            w_good_cnt_nxt = '0;
                            w_locked_nxt   = 1'b0;
                        end
                    end else if (w_to_hit) begin
                        w_state_nxt    = S_ARM;
                        w_to_cnt_nxt   = '0;
                        w_stuck_nxt    = 1'b1;
                        w_good_cnt_nxt = '0;
                        w_locked_nxt   = 1'b0;
                    end else begin
                        w_to_cnt_nxt  = r_to_cnt + TO_W'(1);
                        w_per_cnt_nxt = (r_per_cnt == CNT_MAX) ? r_per_cnt : r_per_cnt + CNT_W'(1);
                        if (w_s) begin
                            w_hi_cnt_nxt = (r_hi_cnt == CNT_MAX) ? r_hi_cnt : r_hi_cnt + CNT_W'(1);
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.meas_valid = r_meas_valid;
    assign bus.period     = r_period;
    assign bus.high_time  = r_high_time;
    assign bus.err_period = r_err_period;
    assign bus.err_duty   = r_err_duty;
    assign bus.stuck      = r_stuck;
    assign bus.locked     = r_locked;
endmodule

// File: doc/clk_monitor.md
Name: clk_monitor

Overview:
Synthesizable frequency/duty checker placed directly downstream of the clock generator. It samples the generated clock (`mon_clk`) in the system clock domain and measures its period and high time in `clk` cycles. It compares each measurement against expected limits and reports per-measurement errors, a stuck-clock timeout and a `locked` status. Used on silicon and in the bench to qualify generator configurations (frequency, duty, enable on/off).

Parameters:
- CNT_W, 16: width of measurement counters and outputs.
- SYNC_STAGES, 2: flops in the `mon_clk` synchronizer, minimum 2.
- EXP_PERIOD, 10: expected `mon_clk` period, in `clk` cycles.
- PERIOD_TOL, 1: allowed absolute period deviation, in `clk` cycles.
- MIN_HIGH, 4: minimum acceptable high time, in `clk` cycles.
- MAX_HIGH, 6: maximum acceptable high time, in `clk` cycles.
- TIMEOUT, 1000: number of `clk` cycles without a rising edge before `stuck` is raised.
- LOCK_COUNT, 4: consecutive good measurements required to assert `locked`.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  monitor enable, synchronous to `clk`.
- mon_clk  in  1  monitored clock, asynchronous to `clk`.
- meas_valid  out  1  one-cycle pulse; a new measurement is on the outputs.
- period  out  CNT_W  last measured period, in `clk` cycles.
- high_time  out  CNT_W  last measured high time, in `clk` cycles.
- err_period  out  1  last period is outside EXP_PERIOD ± PERIOD_TOL.
- err_duty  out  1  last high time is outside [MIN_HIGH, MAX_HIGH].
- stuck  out  1  no rising edge within TIMEOUT cycles.
- locked  out  1  LOCK_COUNT consecutive good measurements seen.

Behaviour:
- Reset state:
  - All outputs are 0; all counters are 0.
  - State is IDLE; the synchronizer chain and the edge-detect flop are 0.
- Synchronizer:
  - `mon_clk` passes through SYNC_STAGES flops to give `s`, plus one more flop `s_d`.
  - `rise` = `s` & ~`s_d`. All measurement uses `s` and `rise` only.
- State machine:
  - IDLE: entered when `enable`=0 from any state.
    - Counters are cleared; `locked`, `stuck` and `meas_valid` are 0.
    - `period`, `high_time`, `err_period` and `err_duty` hold their last values.
    - Goes to ARM when `enable`=1.
  - ARM: waits for the first `rise`; no measurement is produced.
    - On `rise`: per_cnt<=1, hi_cnt<=1, go to MEASURE.
    - The timeout counter runs in ARM as well.
  - MEASURE, each cycle without `rise`:
    - per_cnt increments.
    - hi_cnt increments when `s`=1.
  - MEASURE, on `rise`:
    - period<=per_cnt and high_time<=hi_cnt.
    - err flags are updated and `meas_valid`=1 for exactly that cycle.
    - per_cnt<=1 and hi_cnt<=1.
- Latency: `meas_valid`, `period`, `high_time` and the err flags are registered. They update on the cycle after the `rise` cycle.
- Counter width: per_cnt and hi_cnt saturate at 2^CNT_W−1 and never wrap.
- Error rules:
  - `err_period` = (period > EXP_PERIOD+PERIOD_TOL) or (period + PERIOD_TOL < EXP_PERIOD). The comparison is unsigned and must not underflow.
  - `err_duty` = high_time < MIN_HIGH or high_time > MAX_HIGH.
- Lock:
  - good_cnt increments on each valid measurement with both err flags 0, saturating at LOCK_COUNT.
  - Any measurement with an error, or any timeout, clears good_cnt and `locked`.
  - `locked`=1 when good_cnt==LOCK_COUNT.
- Timeout:
  - A cycle counter runs in ARM/MEASURE and clears on `rise`.
  - When it reaches TIMEOUT: `stuck`<=1, good_cnt<=0, `locked`<=0, go to ARM.
  - `stuck` stays set until the next `rise`, `enable`=0, or `rst`.
- Simultaneous events:
  - `rise` on the same cycle as TIMEOUT: `rise` wins and no timeout occurs.
  - `enable` falling on a `rise` cycle: IDLE wins and no measurement is issued.
- `rst` asserted mid-measurement returns everything to the reset state on the next edge. `rst` has priority over `enable`.

Test Plan:
- `mon_clk` period 10, high 5, `enable`=1 → first `rise` gives no `meas_valid`. Then each period gives period=10, high_time=5, err=0. `locked`=1 after the 4th measurement.
- `mon_clk` period 12, high 6 → `err_period`=1, `err_duty`=0, `locked` stays 0. A return to 10/5 relocks after 4 measurements.
- High time 8 of a period of 10 → `err_duty`=1, `locked` drops on that `meas_valid`.
- `mon_clk` held low after lock → `stuck`=1 exactly TIMEOUT cycles after the last `rise`, `locked`=0. The next edges go through ARM and then resume measurement.
- `enable` deasserted mid-period → IDLE, with `locked`/`stuck`/`meas_valid` at 0 and `period` held. Re-enable → ARM, with no measurement on the first `rise`.
- `rst` pulsed for 1 cycle mid-measurement while locked → all outputs are 0 on the next cycle. The first measurement after reset comes on the second `rise`.
